booth_r4_mul: RTL and testbench

Parametrised radix-4 (modified Booth) sequential multiplier: full datapath plus control FSM, WIDTH-bit operands, 2·WIDTH-bit product. It supports a per-operation signed/unsigned mode, a start/busy/done handshake, and synchronous abort. It is the successor of the fixed-width Booth control unit and is instantiated wherever the ALU needs a multi-cycle multiply.

---
 rtl/booth_r4_mul.sv | 143 ++++++++++++++
 tb/tb_booth_r4_mul.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul.sv
// Radix-4 modified Booth sequential multiplier: WIDTH x WIDTH -> 2*WIDTH,
// signed or unsigned per operation, start/busy/done handshake with abort.
module booth_r4_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int K  = WIDTH / 2 + 1;
  localparam int CW = $clog2(K);
  localparam int AW = WIDTH + 3;
  localparam int QW = WIDTH + 2;
  localparam int SW = AW + QW + 3;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] acc;
  logic [QW-1:0] qr;
  logic          q_1;
  logic [AW-1:0] mr;
  logic [CW-1:0] count;

  logic [AW-1:0] addend;
  logic [AW-1:0] acc_sum;
  logic [SW-1:0] wide;
  logic [AW-1:0] acc_sh;
  logic [QW-1:0] qr_sh;
  logic          q1_sh;
  logic [QW-1:0] ext_q;
  logic [AW-1:0] ext_m;

  // Two extra top bits let the final partial product absorb the unsigned
  // case as well as the signed one, so the same K iterations serve both.
  always_comb begin
    ext_q = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                        : {2'b00, multiplier};
    ext_m = signed_mode ? {{3{multiplicand[WIDTH-1]}}, multiplicand}
                        : {3'b000, multiplicand};
  end

  always_comb begin
    addend = '0;
    unique case ({qr[1:0], q_1})
      3'b001, 3'b010: addend = mr;
      3'b011:         addend = mr << 1;
      3'b100:         addend = -(mr << 1);
      3'b101, 3'b110: addend = -mr;
      default:        addend = '0;
    endcase
    acc_sum = acc + addend;
  end

  // Arithmetic shift of {acc,qr,q_1} by two: replicate the accumulator MSB
  // above the concatenation and take the upper slice.
  always_comb begin
    wide   = {{2{acc[AW-1]}}, acc, qr, q_1};
    acc_sh = wide[SW-1:QW+3];
    qr_sh  = wide[QW+2:3];
    q1_sh  = wide[2];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ADD;
      ADD:   state_nxt = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)              state_nxt = IDLE;
        else if (count == LAST) state_nxt = DONE;
        else                    state_nxt = ADD;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc     <= '0;
      qr      <= '0;
      q_1     <= 1'b0;
      mr      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            qr    <= ext_q;
            q_1   <= 1'b0;
            mr    <= ext_m;
            count <= '0;
          end
        end
        ADD: begin
          acc <= acc_sum;
        end
        SHIFT: begin
          acc <= acc_sh;
          qr  <= qr_sh;
          q_1 <= q1_sh;
          // An aborted operation must leave the previous product intact.
          if (!abort) begin
            if (count == LAST) product <= {acc_sh[WIDTH-3:0], qr_sh};
            else               count   <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Directed bench for booth_r4_mul: WIDTH=8 and WIDTH=16 instances, checking
// products, latency, handshake, ignored restart, abort and async reset.
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  logic        start8 = 1'b0, sm8 = 1'b0, ab8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start16 = 1'b0, sm16 = 1'b0, ab16 = 1'b0;
  logic [15:0] m16 = '0, q16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  int vectors = 0;
  int miscompares = 0;
  int doneCnt8 = 0;

  always #5 clk = ~clk;

  booth_r4_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8), .abort(ab8),
    .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8), .product(prod8)
  );

  booth_r4_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16), .abort(ab16),
    .multiplicand(m16), .multiplier(q16), .busy(busy16), .done(done16), .product(prod16)
  );

  // Count done pulses of the 8-bit instance at the edge that ends each cycle.
  always @(posedge clk) begin
    if (done8) doneCnt8 <= doneCnt8 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit w16, input logic st, input logic s, input logic ab,
                               input logic [15:0] m, input logic [15:0] q);
    if (w16) begin
      start16 = st; sm16 = s; ab16 = ab; m16 = m; q16 = q;
    end else begin
      start8 = st; sm8 = s; ab8 = ab; m8 = m[7:0]; q8 = q[7:0];
    end
  endtask

  task automatic runOp(input string tag, input bit w16, input logic s, input logic ab,
                       input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    applyStimulus(w16, 1'b1, s, ab, m, q);
    @(negedge clk);
    applyStimulus(w16, 1'b0, s, 1'b0, m, q);
    cyc = 1;
    checkOutput({tag, "_busy"}, {31'b0, (w16 ? busy16 : busy8)}, 32'd1);
    while (!(w16 ? done16 : done8) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc - 1), w16 ? 32'd18 : 32'd10);
    checkOutput({tag, "_product"}, w16 ? prod16 : {16'b0, prod8}, exp);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'b0, (w16 ? busy16 : busy8), (w16 ? done16 : done8)}, 32'd0);
  endtask

  initial begin
    int d0;
    int cyc;

    #3;
    checkOutput("reset_outputs8", {14'b0, busy8, done8, prod8}, 32'd0);
    checkOutput("reset_product16", prod16, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    runOp("s_m7x3",     1'b0, 1'b1, 1'b0, 16'h00F9, 16'h0003, 32'h0000FFEB);
    runOp("u_ffxff",    1'b0, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01);
    runOp("s_ffxff",    1'b0, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h00000001);
    runOp("s_80x80",    1'b0, 1'b1, 1'b0, 16'h0080, 16'h0080, 32'h00004000);
    runOp("u_80x02",    1'b0, 1'b0, 1'b0, 16'h0080, 16'h0002, 32'h00000100);
    runOp("s_80x02",    1'b0, 1'b1, 1'b0, 16'h0080, 16'h0002, 32'h0000FF00);
    runOp("s_7fx81",    1'b0, 1'b1, 1'b0, 16'h007F, 16'h0081, 32'h0000C0FF);
    runOp("u_0cx0d",    1'b0, 1'b0, 1'b0, 16'h000C, 16'h000D, 32'h0000009C);
    runOp("u_00xa5",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5, 32'h00000000);
    // Abort alongside start in IDLE must not cancel the request.
    runOp("s_ffx01_ab", 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0001, 32'h0000FFFF);

    // A second start mid-operation is ignored.
    d0 = doneCnt8;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h00F9, 16'h0003);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h00F9, 16'h0003);
    cyc = 1;
    repeat (2) begin @(negedge clk); cyc++; end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 16'h0022);
    @(negedge clk); cyc++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0055, 16'h0022);
    while (!done8 && cyc < 60) begin @(negedge clk); cyc++; end
    checkOutput("restart_latency", 32'(cyc - 1), 32'd10);
    checkOutput("restart_product", {16'b0, prod8}, 32'h0000FFEB);
    repeat (4) @(negedge clk);
    checkOutput("restart_done_pulses", 32'(doneCnt8 - d0), 32'd1);

    // Abort in cycle 5.
    d0 = doneCnt8;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0034);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0034);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 16'h0034);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0034);
    checkOutput("abort_busy", {31'b0, busy8}, 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCnt8 - d0), 32'd0);
    checkOutput("abort_product_held", {16'b0, prod8}, 32'h0000FFEB);
    runOp("u_12x34",    1'b0, 1'b0, 1'b0, 16'h0012, 16'h0034, 32'h000003A8);

    // Asynchronous reset in cycle 4.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h007F, 16'h007F);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h007F, 16'h007F);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {14'b0, busy8, done8, prod8}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_reset_idle", {14'b0, busy8, done8, prod8}, 32'd0);
    runOp("s_7fx7f",    1'b0, 1'b1, 1'b0, 16'h007F, 16'h007F, 32'h00003F01);

    runOp("w16_s_8000x7fff", 1'b1, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 32'hC0008000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
